// File: rtl/bus_uart_tx_if.sv
// rtl/bus_uart_tx_if.sv - peripheral write bus bundle between the pipeline and the UART transmitter
interface bus_uart_tx_if;
   logic [31:0] bus_din;
   logic [31:0] bus_addr;
   logic        bus_write_valid;
   logic        bus_write_ready;

   modport master (
      output bus_din,
      output bus_addr,
      output bus_write_valid,
      input  bus_write_ready
   );

   modport slave (
      input  bus_din,
      input  bus_addr,
      input  bus_write_valid,
      output bus_write_ready
   );
endinterface

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and programmable divisor
module bus_uart_tx #(
   parameter int FIFO_DEPTH      = 16,
   parameter int DEFAULT_DIVISOR = 868,
   parameter int DIV_WIDTH       = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   bus_uart_tx_if.slave                    bus,
   output logic                            uart_tx,
   output logic                            tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIVISOR);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [7:0]           fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
   logic [DIV_WIDTH-1:0] bit_len_q, bit_len_d;
   logic [DIV_WIDTH-1:0] baud_q, baud_d;
   logic [7:0]           shift_q, shift_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 tx_q, tx_d;

   logic is_txdata, is_divisor, fifo_full, fifo_empty;
   logic accept, push, pop, bit_end;
   logic unused_bus_bits;

   // Only addr[3:2] is decoded; the rest of the bus word is don't-care here.
   assign unused_bus_bits = ^{bus.bus_addr[31:4], bus.bus_addr[1:0], bus.bus_din};

   assign is_txdata  = (bus.bus_addr[3:2] == 2'd0);
   assign is_divisor = (bus.bus_addr[3:2] == 2'd1);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   // Ready depends on address and full flag only so the pipeline stall cannot loop back through valid.
   assign bus.bus_write_ready = !(is_txdata && fifo_full);
   assign accept  = bus.bus_write_valid && bus.bus_write_ready;
   assign push    = accept && is_txdata;
   assign pop     = (state_q == IDLE) && !fifo_empty;
   assign bit_end = (baud_q == '0);

   assign uart_tx    = tx_q;
   assign fifo_count = count_q;
   assign tx_busy    = (state_q != IDLE) || !fifo_empty;

   // FIFO bookkeeping and divisor register next state.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      divisor_d = divisor_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (accept && is_divisor) begin
         divisor_d = (bus.bus_din[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : bus.bus_din[DIV_WIDTH-1:0];
      end
   end

   // Frame sequencer: next state, shifter, baud counter and registered line value.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      bit_len_d = bit_len_q;
      baud_d    = baud_q;
      tx_d      = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               shift_d   = fifo_mem_q[rd_ptr_q];
               bit_len_d = divisor_q;
               baud_d    = divisor_q - 1'b1;
               state_d   = START;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d    = bit_len_q - 1'b1;
               bit_idx_d = 3'd0;
               state_d   = DATA;
               tx_d      = shift_q[0];
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d    = bit_len_q - 1'b1;
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d  = bit_len_q - 1'b1;
               state_d = IDLE;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-frame abandons the frame and the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         divisor_q <= DIV_RESET;
         bit_len_q <= DIV_RESET;
         baud_q    <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         divisor_q <= divisor_d;
         bit_len_q <= bit_len_d;
         baud_q    <= baud_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   // FIFO storage; contents are meaningless while count is zero so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= bus.bus_din[7:0];
      end
   end
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb/tb_bus_uart_tx.sv - self-checking bench for bus_uart_tx
module tb_bus_uart_tx;
   localparam int FIFO_DEPTH = 4;
   localparam int DEF_DIV    = 4;
   localparam int DIV_WIDTH  = 16;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] A_TX   = 32'hE000_0000;
   localparam logic [31:0] A_DIV  = 32'hE000_0004;
   localparam logic [31:0] A_RES3 = 32'hE000_000C;

   typedef struct {
      logic [31:0] addr;
      logic        exp_ready_full;
   } rdy_vec_t;

   typedef struct {
      logic [31:0] din;
      int          bit_len;
   } div_vec_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             uart_tx;
   logic             tx_busy;
   logic [CNT_W-1:0] fifo_count;

   bus_uart_tx_if bus_if();

   bus_uart_tx #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .DEFAULT_DIVISOR(DEF_DIV),
      .DIV_WIDTH(DIV_WIDTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus_if),
      .uart_tx(uart_tx),
      .tx_busy(tx_busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model: bytes in acceptance order, divisor register value, observed frame starts.
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         div_model = DEF_DIV;
   int         div_prev  = DEF_DIV;
   int         mon_idx   = 0;
   int         mon_k     = 0;
   int         mon_d     = 1;
   bit         mon_active = 1'b0;
   logic [7:0] mon_byte;

   rdy_vec_t rdy_tab[6];
   div_vec_t div_tab[7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input int max_wait,
                            output int acc_cyc, output int waited);
      bus_if.bus_addr        = addr;
      bus_if.bus_din         = data;
      bus_if.bus_write_valid = 1'b1;
      waited  = 0;
      acc_cyc = -1;
      forever begin
         @(negedge clk);
         if (bus_if.bus_write_ready === 1'b1) begin
            acc_cyc = cyc;
            break;
         end
         if (waited >= max_wait) break;
         waited++;
      end
      if (acc_cyc < 0) begin
         bus_if.bus_write_valid = 1'b0;
         check("write_accept_timeout", 32'd0, 32'd1);
         tick();
      end else begin
         tick();
         bus_if.bus_write_valid = 1'b0;
         case (addr[3:2])
            2'd0:    exp_q.push_back(data[7:0]);
            2'd1:    div_model = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
            default: ;
         endcase
      end
   endtask

   task automatic wait_idle(input int max_cyc, output int drop_cyc);
      drop_cyc = -1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (tx_busy === 1'b0) begin
            drop_cyc = cyc;
            break;
         end
      end
      if (drop_cyc < 0) check("idle_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // Line checker: each frame is start(0), 8 data bits LSB first, stop(1), D cycles each,
   // where D is the divisor value held in the cycle before the start bit appears.
   task automatic monitor_loop();
      int   bi;
      logic expb;
      forever begin
         @(negedge clk);
         if (!mon_active && uart_tx === 1'b0) begin
            if (mon_idx >= exp_q.size()) begin
               check("spurious_start", 32'd1, 32'd0);
            end else begin
               mon_active = 1'b1;
               mon_k      = 0;
               mon_d      = div_prev;
               mon_byte   = exp_q[mon_idx];
               mon_idx++;
               start_q.push_back(cyc);
            end
         end
         if (mon_active) begin
            bi = mon_k / mon_d;
            if (bi == 0) expb = 1'b0;
            else if (bi <= 8) expb = mon_byte[bi-1];
            else expb = 1'b1;
            check("line_bit", 32'(uart_tx), 32'(expb));
            mon_k++;
            if (mon_k == 10 * mon_d) mon_active = 1'b0;
         end
         div_prev = div_model;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int acc, w, drop, base, s, pushed, r;
      int acc_first;
      logic [31:0] addr, data;

      rdy_tab[0] = '{32'hE000_0000, 1'b0};
      rdy_tab[1] = '{32'hE000_0004, 1'b1};
      rdy_tab[2] = '{32'hE000_0008, 1'b1};
      rdy_tab[3] = '{32'hE000_000C, 1'b1};
      rdy_tab[4] = '{32'hE000_0013, 1'b0};
      rdy_tab[5] = '{32'hE123_4564, 1'b1};

      div_tab[0] = '{32'h0000_0000, 1};
      div_tab[1] = '{32'h0000_0001, 1};
      div_tab[2] = '{32'h0000_0002, 2};
      div_tab[3] = '{32'h0000_0003, 3};
      div_tab[4] = '{32'h0000_0005, 5};
      div_tab[5] = '{32'hABCD_0006, 6};
      div_tab[6] = '{32'h0000_0004, 4};

      bus_if.bus_addr        = A_TX;
      bus_if.bus_din         = '0;
      bus_if.bus_write_valid = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      fork
         monitor_loop();
      join_none

      // Reset state.
      @(negedge clk);
      check("reset_uart_tx", 32'(uart_tx), 32'd1);
      check("reset_fifo_count", 32'(fifo_count), 32'd0);
      check("reset_tx_busy", 32'(tx_busy), 32'd0);
      tick();
      foreach (rdy_tab[i]) begin
         bus_if.bus_addr = rdy_tab[i].addr;
         @(negedge clk);
         check("ready_empty", 32'(bus_if.bus_write_ready), 32'd1);
         tick();
      end

      // Single byte 0x55: count 1 next cycle, start bit two cycles after acceptance, 10*D frame.
      repeat (5) tick();
      bus_write(A_TX, 32'h55, 4, acc, w);
      @(negedge clk);
      check("t1_fifo_count", 32'(fifo_count), 32'd1);
      check("t1_line_idle", 32'(uart_tx), 32'd1);
      check("t1_busy", 32'(tx_busy), 32'd1);
      wait_idle(200, drop);
      check("t1_busy_drop", drop, acc + 2 + 10 * DEF_DIV);
      check("t1_start_cycle", start_q[start_q.size()-1], acc + 2);
      check("t1_all_sent", mon_idx, exp_q.size());

      // Fill the FIFO with valid held, probe ready decode while full, then stall on the next push.
      base = start_q.size();
      for (int i = 1; i <= 5; i++) begin
         bus_write(A_TX, 32'(i), 0, acc, w);
         if (i == 1) acc_first = acc;
      end
      @(negedge clk);
      check("t2_full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
      tick();
      foreach (rdy_tab[i]) begin
         bus_if.bus_addr = rdy_tab[i].addr;
         @(negedge clk);
         check("ready_full", 32'(bus_if.bus_write_ready), 32'(rdy_tab[i].exp_ready_full));
         tick();
      end
      bus_write(A_RES3, 32'hFF, 0, acc, w);
      check("t2_reserved_wait", w, 0);
      @(negedge clk);
      check("t2_reserved_count", 32'(fifo_count), 32'(FIFO_DEPTH));
      tick();
      bus_write(A_TX, 32'h06, 200, acc, w);
      check("t2_first_start", start_q[base], acc_first + 2);
      check("t2_stall_release", acc, start_q[base] + 10 * DEF_DIV + 1);
      wait_idle(1000, drop);
      check("t2_frame_total", start_q.size(), base + 6);
      if (start_q.size() == base + 6) begin
         for (int k = 1; k < 6; k++) begin
            check("t2_start_spacing", start_q[base+k] - start_q[base+k-1], 10 * DEF_DIV + 1);
         end
      end
      check("t2_all_sent", mon_idx, exp_q.size());

      // Divisor changed mid-frame: current frame keeps D=4, next frame uses 2.
      base = start_q.size();
      bus_write(A_TX, 32'hA5, 4, acc, w);
      bus_write(A_TX, 32'h3C, 4, acc, w);
      repeat (10) tick();
      bus_write(A_DIV, 32'd2, 0, acc, w);
      wait_idle(500, drop);
      check("t3_frame_total", start_q.size(), base + 2);
      if (start_q.size() == base + 2) begin
         check("t3_old_div_frame", start_q[base+1] - start_q[base], 10 * DEF_DIV + 1);
         check("t3_new_div_frame", drop, start_q[base+1] + 10 * 2);
      end

      // Divisor table: busy spans from acceptance to 10 bit-times after the start bit.
      foreach (div_tab[i]) begin
         bus_write(A_DIV, div_tab[i].din, 0, acc, w);
         bus_write(A_TX, 32'($urandom_range(0, 255)), 4, acc, w);
         wait_idle(500, drop);
         check("div_table_frame", drop - acc, 10 * div_tab[i].bit_len + 2);
      end

      // Reset during data bit 3 with bytes still queued.
      bus_write(A_DIV, 32'd3, 0, acc, w);
      base = start_q.size();
      bus_write(A_TX, 32'hC3, 4, acc, w);
      bus_write(A_TX, 32'h81, 4, acc, w);
      bus_write(A_TX, 32'h7E, 4, acc, w);
      s = (start_q.size() > base) ? start_q[base] : cyc;
      for (int i = 0; i < 200 && cyc < s + 4 * 3 + 1; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mon_active = 1'b0;
      mon_idx    = exp_q.size();
      div_model  = DEF_DIV;
      @(negedge clk);
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      tick();
      repeat (100) tick();
      check("rst_no_more_frames", start_q.size(), base + 1);
      bus_write(A_TX, 32'h0F, 4, acc, w);
      wait_idle(500, drop);
      check("rst_default_div", drop - acc, 10 * DEF_DIV + 2);

      // Randomized traffic at max push rate, wrapping the FIFO several times.
      bus_write(A_DIV, 32'($urandom_range(0, 3)), 0, acc, w);
      base   = start_q.size();
      pushed = 0;
      while (pushed < 3 * FIFO_DEPTH) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            addr = {4'hE, 24'($urandom), 2'b00, 2'($urandom)};
            data = {24'($urandom), 8'($urandom_range(0, 255))};
            pushed++;
         end else if (r == 7) begin
            addr = A_DIV;
            data = {16'($urandom), 16'($urandom_range(0, 4))};
         end else begin
            addr = 32'hE000_0008 + 32'($urandom_range(0, 1) * 4);
            data = $urandom;
         end
         bus_write(addr, data, 200, acc, w);
      end
      wait_idle(3000, drop);
      check("rand_frame_total", start_q.size() - base, 3 * FIFO_DEPTH);
      check("rand_all_sent", mon_idx, exp_q.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
